// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
package fetch_stage_pkg;

    // Fetch FSM: REQ issues, WAIT awaits the response, HOLD parks a stalled
    // response, DROP swallows a response that belongs to a wrong path.
    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2,
        StDrop = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with write enable, flush and valid bit.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               write_en,
    input  logic               flush,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc_plus4,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic               valid
);

    // Flush beats load, load beats bubble insertion; write_en=0 holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= INSTR_W'(NOP_INSTR);
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr <= INSTR_W'(NOP_INSTR);
            valid <= 1'b0;
        end else if (load) begin
            instr    <= load_instr;
            pc_plus4 <= load_pc_plus4;
            valid    <= 1'b1;
        end else if (write_en) begin
            instr <= INSTR_W'(NOP_INSTR);
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one-outstanding fetch FSM, hold buffer, IF/ID.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               PCWrite,
    input  logic               IFIDWrite,
    input  logic               IFIDFlush,
    input  logic               BranchTaken,
    input  logic [ADDR_W-1:0]  BranchTarget,
    output logic               IMemReq,
    output logic [ADDR_W-1:0]  IMemAddr,
    input  logic               IMemReady,
    input  logic               IMemRspValid,
    input  logic [INSTR_W-1:0] IMemRspData,
    output logic [INSTR_W-1:0] IFIDInstr,
    output logic [ADDR_W-1:0]  IFIDPCPlus4,
    output logic               IFIDValid,
    output logic [15:0]        BubbleCount
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic [15:0]        bubble_q;
    logic               advance;
    logic               load;
    logic [INSTR_W-1:0] load_instr;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  branch_pc;

    assign advance   = PCWrite & IFIDWrite;
    assign pc_plus4  = pc_q + ADDR_W'(PC_INC);
    assign branch_pc = {BranchTarget[ADDR_W-1:2], 2'b00};
    assign IMemReq   = (state_q == StReq);
    assign IMemAddr  = pc_q;

    // Next state, next PC and IF/ID load; a redirect overrides every stall.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        load       = 1'b0;
        load_instr = hold_q;
        if (BranchTaken) begin
            pc_d = branch_pc;
            unique case (state_q)
                StReq:   state_d = IMemReady ? StDrop : StReq;
                // A response arriving now is the wrong-path one; nothing is left in flight.
                StWait:  state_d = IMemRspValid ? StReq : StDrop;
                StHold:  state_d = StReq;
                default: state_d = StDrop;
            endcase
        end else begin
            unique case (state_q)
                StReq: begin
                    if (IMemReady) state_d = StWait;
                end
                StWait: begin
                    if (IMemRspValid) begin
                        if (advance) begin
                            load       = 1'b1;
                            load_instr = IMemRspData;
                            pc_d       = pc_plus4;
                            state_d    = StReq;
                        end else begin
                            hold_d  = IMemRspData;
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (advance) begin
                        load    = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = StReq;
                    end
                end
                default: begin
                    if (IMemRspValid) state_d = StReq;
                end
            endcase
        end
    end

    // FSM, PC and hold buffer state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StReq;
            pc_q    <= RESET_PC;
            hold_q  <= INSTR_W'(NOP_INSTR);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    // Saturating count of cycles where ID sees a bubble.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bubble_q <= '0;
        end else if (!IFIDValid && (bubble_q != 16'hFFFF)) begin
            bubble_q <= bubble_q + 16'd1;
        end
    end

    assign BubbleCount = bubble_q;

    fetch_stage_if_id_reg #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_if_id_reg (
        .clk          (Clk),
        .rst_n        (Reset_n),
        .write_en     (IFIDWrite),
        .flush        (IFIDFlush | BranchTaken),
        .load         (load),
        .load_instr   (load_instr),
        .load_pc_plus4(pc_plus4),
        .instr        (IFIDInstr),
        .pc_plus4     (IFIDPCPlus4),
        .valid        (IFIDValid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a reactive memory model and a load scoreboard.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        PCWrite, IFIDWrite, IFIDFlush, BranchTaken;
    logic [31:0] BranchTarget;
    logic        IMemReq, IMemReady;
    logic [31:0] IMemAddr;
    logic        IMemRspValid = 1'b0;
    logic [31:0] IMemRspData  = 32'h0;
    logic [31:0] IFIDInstr, IFIDPCPlus4;
    logic        IFIDValid;
    logic [15:0] BubbleCount;

    // Second instance exercising PC wrap-around; shares all inputs.
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pcp4;
    logic [15:0] w_bubble;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcp4;
    } exp_t;
    exp_t sb[$];

    int          mem_lat  = 1;
    int          mem_wait = 0;
    logic [31:0] mem_addr = 32'h0;

    always #5 Clk = ~Clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IFIDFlush(IFIDFlush), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady),
        .IMemRspValid(IMemRspValid), .IMemRspData(IMemRspData), .IFIDInstr(IFIDInstr),
        .IFIDPCPlus4(IFIDPCPlus4), .IFIDValid(IFIDValid), .BubbleCount(BubbleCount)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .Clk(Clk), .Reset_n(Reset_n), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IFIDFlush(IFIDFlush), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .IMemReq(w_req), .IMemAddr(w_addr), .IMemReady(IMemReady),
        .IMemRspValid(IMemRspValid), .IMemRspData(IMemRspData), .IFIDInstr(w_instr),
        .IFIDPCPlus4(w_pcp4), .IFIDValid(w_valid), .BubbleCount(w_bubble)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return 32'hA000_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction memory: answers mem_lat cycles after acceptance, forgets on reset.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            IMemRspValid <= 1'b0;
            mem_wait     <= 0;
        end else begin
            IMemRspValid <= 1'b0;
            if (IMemReq && IMemReady) begin
                if (mem_lat <= 1) begin
                    IMemRspValid <= 1'b1;
                    IMemRspData  <= mem_data(IMemAddr);
                end else begin
                    mem_wait <= mem_lat - 1;
                    mem_addr <= IMemAddr;
                end
            end else if (mem_wait == 1) begin
                IMemRspValid <= 1'b1;
                IMemRspData  <= mem_data(mem_addr);
                mem_wait     <= 0;
            end else if (mem_wait > 1) begin
                mem_wait <= mem_wait - 1;
            end
        end
    end

    // Scoreboard: every new valid IF/ID content must match the next expected load.
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pcp4  = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    always @(negedge Clk) begin
        if (IFIDValid && (!prev_valid || IFIDPCPlus4 !== prev_pcp4 || IFIDInstr !== prev_instr)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected_load: observed pc+4 %h expected no load", IFIDPCPlus4);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("load_instr", IFIDInstr, e.instr);
                chk("load_pcp4", IFIDPCPlus4, e.pcp4);
            end
        end
        prev_valid <= IFIDValid;
        prev_pcp4  <= IFIDPCPlus4;
        prev_instr <= IFIDInstr;
    end

    initial begin
        Reset_n      = 1'b0;
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        IFIDFlush    = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = 32'h0;
        IMemReady    = 1'b1;
        repeat (2) @(negedge Clk);

        // Reset state
        chk("rst_valid", {31'h0, IFIDValid}, 32'h0);
        chk("rst_instr", IFIDInstr, 32'h0);
        chk("rst_pcp4", IFIDPCPlus4, 32'h0);
        chk("rst_bubble", {16'h0, BubbleCount}, 32'h0);
        chk("rst_addr", IMemAddr, 32'h0);

        // Single fetch, 1-cycle memory
        sb.push_back({mem_data(32'h0), 32'h4});
        Reset_n = 1'b1;
        #1;
        chk("t1_req", {31'h0, IMemReq}, 32'h1);
        chk("t1_addr0", IMemAddr, 32'h0);
        @(negedge Clk);
        IMemReady = 1'b0;
        chk("t1_wait_req", {31'h0, IMemReq}, 32'h0);
        @(negedge Clk);
        chk("t1_valid", {31'h0, IFIDValid}, 32'h1);
        chk("t1_addr4", IMemAddr, 32'h4);
        chk("t1_bubble", {16'h0, BubbleCount}, 32'h2);
        chk("wrap_addr", w_addr, 32'h0);
        chk("wrap_pcp4", w_pcp4, 32'h0);

        // Response lands during a 3-cycle stall and is parked in HOLD
        sb.push_back({mem_data(32'h4), 32'h8});
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IMemReady = 1'b1;
        @(negedge Clk);
        IMemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_hold_valid", {31'h0, IFIDValid}, 32'h1);
            chk("t2_hold_pcp4", IFIDPCPlus4, 32'h4);
            chk("t2_hold_addr", IMemAddr, 32'h4);
            chk("t2_hold_req", {31'h0, IMemReq}, 32'h0);
            if (i < 3) @(negedge Clk);
        end
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        @(negedge Clk);
        chk("t2_pcp4", IFIDPCPlus4, 32'h8);
        chk("t2_addr", IMemAddr, 32'h8);
        chk("t2_req", {31'h0, IMemReq}, 32'h1);

        // Branch while waiting; late response must be dropped
        mem_lat   = 3;
        IMemReady = 1'b1;
        @(negedge Clk);
        IMemReady    = 1'b0;
        BranchTaken  = 1'b1;
        BranchTarget = 32'h0000_0043;
        @(negedge Clk);
        BranchTaken = 1'b0;
        chk("t3_addr", IMemAddr, 32'h40);
        chk("t3_req", {31'h0, IMemReq}, 32'h0);
        chk("t3_valid", {31'h0, IFIDValid}, 32'h0);
        @(negedge Clk);
        chk("t3_drop_req", {31'h0, IMemReq}, 32'h0);
        @(negedge Clk);
        chk("t3_req_again", {31'h0, IMemReq}, 32'h1);
        chk("t3_addr_again", IMemAddr, 32'h40);
        chk("t3_valid_after", {31'h0, IFIDValid}, 32'h0);
        chk("t3_instr_after", IFIDInstr, 32'h0);

        // Branch overrides a full stall and flushes IF/ID
        sb.push_back({mem_data(32'h40), 32'h44});
        mem_lat   = 1;
        IMemReady = 1'b1;
        @(negedge Clk);
        IMemReady = 1'b0;
        @(negedge Clk);
        chk("t4_loaded", {31'h0, IFIDValid}, 32'h1);
        PCWrite      = 1'b0;
        IFIDWrite    = 1'b0;
        BranchTaken  = 1'b1;
        BranchTarget = 32'h0000_0100;
        @(negedge Clk);
        BranchTaken = 1'b0;
        chk("t4_valid", {31'h0, IFIDValid}, 32'h0);
        chk("t4_instr", IFIDInstr, 32'h0);
        chk("t4_addr", IMemAddr, 32'h100);
        chk("t4_req", {31'h0, IMemReq}, 32'h1);
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;

        // Hazard flush beats IFIDWrite=0
        sb.push_back({mem_data(32'h100), 32'h104});
        IMemReady = 1'b1;
        @(negedge Clk);
        IMemReady = 1'b0;
        @(negedge Clk);
        chk("t5_loaded", {31'h0, IFIDValid}, 32'h1);
        IFIDFlush = 1'b1;
        IFIDWrite = 1'b0;
        PCWrite   = 1'b0;
        @(negedge Clk);
        IFIDFlush = 1'b0;
        IFIDWrite = 1'b1;
        PCWrite   = 1'b1;
        chk("t5_valid", {31'h0, IFIDValid}, 32'h0);
        chk("t5_instr", IFIDInstr, 32'h0);
        chk("t5_addr", IMemAddr, 32'h104);

        // Park in WAIT with a very slow memory; bubbles saturate the counter
        mem_lat   = 100000;
        IMemReady = 1'b1;
        @(negedge Clk);
        IMemReady = 1'b0;
        chk("t6_wait", {31'h0, IMemReq}, 32'h0);
        repeat (66000) @(negedge Clk);
        chk("t6_sat", {16'h0, BubbleCount}, 32'hFFFF);
        repeat (3) @(negedge Clk);
        chk("t6_sat_hold", {16'h0, BubbleCount}, 32'hFFFF);

        // Asynchronous reset mid-cycle while in WAIT
        #2;
        Reset_n = 1'b0;
        #1;
        chk("t7_bubble", {16'h0, BubbleCount}, 32'h0);
        chk("t7_valid", {31'h0, IFIDValid}, 32'h0);
        chk("t7_instr", IFIDInstr, 32'h0);
        chk("t7_pcp4", IFIDPCPlus4, 32'h0);
        chk("t7_addr", IMemAddr, 32'h0);
        chk("t7_req", {31'h0, IMemReq}, 32'h1);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        chk("t7_req_after", {31'h0, IMemReq}, 32'h1);
        repeat (2) @(negedge Clk);
        chk("sb_drained", sb.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline; sits directly upstream of the hazard detection unit and consumes its PCWrite, IFIDWrite and IFIDFlush outputs.
- Owns the PC and issues one-outstanding-request fetches to a variable-latency instruction memory.
- Holds a fetched instruction across load-use/multiply stalls and discards wrong-path fetches on taken branches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width.
- INSTR_W, 32, instruction width.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- PCWrite  in  1  from hazard unit; 0 = freeze PC.
- IFIDWrite  in  1  from hazard unit; 0 = hold IF/ID contents.
- IFIDFlush  in  1  from hazard unit; 1 = IF/ID becomes bubble.
- BranchTaken  in  1  one-cycle redirect pulse from ID.
- BranchTarget  in  ADDR_W  redirect address; bits [1:0] ignored (forced 0).
- IMemReq  out  1  fetch request valid.
- IMemAddr  out  ADDR_W  fetch address (= PC).
- IMemReady  in  1  memory accepts request when IMemReq & IMemReady.
- IMemRspValid  in  1  response valid, exactly one per accepted request.
- IMemRspData  in  INSTR_W  fetched instruction.
- IFIDInstr  out  INSTR_W  instruction to ID.
- IFIDPCPlus4  out  ADDR_W  PC+4 of that instruction.
- IFIDValid  out  1  1 = real instruction, 0 = bubble.
- BubbleCount  out  16  saturating count of cycles with IFIDValid=0.

Behaviour:
- Reset (async, Reset_n=0): PC=RESET_PC, state=REQ, IFIDInstr=0 (NOP), IFIDPCPlus4=0, IFIDValid=0, BubbleCount=0, hold buffer invalid. IMemReq is 1 in the first cycle after release.
- Definition: Advance = PCWrite & IFIDWrite.
- States:
  - REQ: IMemReq=1, IMemAddr=PC. On IMemReady, go to WAIT.
  - WAIT: IMemReq=0, waiting for the response.
    - On IMemRspValid with Advance: load IF/ID with {RspData, PC+4, valid=1}, PC<=PC+4, go to REQ.
    - On IMemRspValid without Advance: capture RspData into hold buffer, go to HOLD.
  - HOLD: on Advance, load IF/ID from hold buffer, PC<=PC+4, go to REQ.
  - DROP: wait for IMemRspValid, discard the data, go to REQ.
- Fetch-to-IF/ID latency: 1 cycle after IMemRspValid when not stalled. Minimum one instruction per 2 cycles with 1-cycle memory.
- IF/ID when not loading:
  - IFIDWrite=0: hold all contents.
  - IFIDWrite=1 with no load: IFIDValid<=0 (bubble), IFIDInstr<=0.
- IFIDFlush=1: IFIDInstr<=0, IFIDValid<=0 regardless of IFIDWrite. Flush beats stall.
- BranchTaken=1 (highest priority, overrides PCWrite=0): PC<=BranchTarget & ~3. Hold buffer is invalidated; IF/ID is flushed. Next state by current state:
  - REQ accepted this cycle: DROP.
  - REQ not accepted: REQ at new PC.
  - WAIT, no response this cycle: DROP.
  - WAIT, response this cycle: discard response, REQ.
  - HOLD: REQ.
  - DROP: stays DROP.
- Unexpected IMemRspValid in REQ: ignored.
- PC arithmetic: modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 wraps to 0. PC[1:0] always 00.
- BubbleCount: increments each cycle IFIDValid=0; saturates at 16'hFFFF.
- Reset mid-WAIT: returns to REQ. A late response after reset release is ignored.

Decomposition:
- Shared pipeline package holds:
  - fetch state encoding (REQ, WAIT, HOLD, DROP);
  - NOP_INSTR = 32'h0000_0000;
  - PC_INC = 4.
- One natural sub-module: if_id_reg, the IF/ID register with write-enable, flush and valid bit. The FSM, PC and hold buffer stay in fetch_stage.

Test Plan:
- Reset release, memory ready always, 1-cycle response with data 32'h2008_0005 → IMemAddr=0 then 4. IFIDInstr=32'h2008_0005, IFIDPCPlus4=4, IFIDValid=1 two cycles after reset release.
- Response arrives while PCWrite=IFIDWrite=0 for 3 cycles → data held in HOLD. IF/ID unchanged for 3 cycles, loaded in cycle 4. PC advances once only.
- BranchTaken with BranchTarget=32'h0000_0040 while in WAIT; response arrives 2 cycles later → response discarded, IFIDValid=0. Next IMemAddr=32'h40.
- BranchTaken in same cycle as IFIDWrite=0 and PCWrite=0 → PC=target, IF/ID flushed to NOP, IFIDValid=0.
- RESET_PC=32'hFFFF_FFFC, one fetch → next IMemAddr=0 (wrap).
- Hold IMemReady=0 for 70000 cycles → BubbleCount saturates at 16'hFFFF. Mid-sequence Reset_n pulse → all outputs return to reset values immediately (asynchronous).
